// File: rtl/cobro_bebida.sv
// Drink vending payment controller: accumulates coins, accepts orders,
// hands off to the dispenser with a timeout guard and pays change one
// unit per pulse.
module cobro_bebida #(
  parameter int CREDITO_MAX    = 15,
  parameter int TIMEOUT_CICLOS = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] moneda,
  input  logic [2:0] seleccion,
  input  logic       pedir,
  input  logic       cancelar,
  input  logic       ocupado,
  output logic       preparar,
  output logic [2:0] tipo_bebida,
  output logic [3:0] credito,
  output logic       vuelto_pulso,
  output logic       rechazo
);

  localparam int          CW   = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [4:0]  CMAX = 5'(CREDITO_MAX);
  localparam logic [CW-1:0] CNT_FIN = CW'(TIMEOUT_CICLOS - 1);

  typedef enum logic [2:0] {ESPERA, LANZAR, INICIO, FIN, VUELTO} estado_t;

  estado_t       estado, estado_nxt;
  logic [3:0]    credito_nxt, precio_q, precio_nxt;
  logic [2:0]    tipo_nxt;
  logic          vuelto_nxt, rechazo_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          pedir_q;

  logic       pedir_flanco, moneda_ok, sel_ok;
  logic [2:0] valor_moneda;
  logic [3:0] precio_sel;
  logic [4:0] suma;

  // Coin value and drink price decode
  always_comb begin
    valor_moneda = 3'd0;
    case (moneda)
      2'b01:   valor_moneda = 3'd1;
      2'b10:   valor_moneda = 3'd2;
      2'b11:   valor_moneda = 3'd5;
      default: valor_moneda = 3'd0;
    endcase
    sel_ok     = 1'b1;
    precio_sel = 4'd0;
    case (seleccion)
      3'b001:  precio_sel = 4'd3;
      3'b010:  precio_sel = 4'd4;
      3'b011:  precio_sel = 4'd5;
      3'b100:  precio_sel = 4'd2;
      default: sel_ok     = 1'b0;
    endcase
  end

  assign moneda_ok    = (moneda != 2'b00);
  assign suma         = {1'b0, credito} + {2'b00, valor_moneda};
  assign pedir_flanco = pedir & ~pedir_q;
  assign preparar     = (estado == LANZAR);

  // State register and all datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado       <= ESPERA;
      credito      <= 4'd0;
      tipo_bebida  <= 3'b000;
      precio_q     <= 4'd0;
      vuelto_pulso <= 1'b0;
      rechazo      <= 1'b0;
      cnt          <= '0;
      pedir_q      <= 1'b0;
    end else begin
      estado       <= estado_nxt;
      credito      <= credito_nxt;
      tipo_bebida  <= tipo_nxt;
      precio_q     <= precio_nxt;
      vuelto_pulso <= vuelto_nxt;
      rechazo      <= rechazo_nxt;
      cnt          <= cnt_nxt;
      pedir_q      <= pedir;
    end
  end

  // Next-state and datapath decisions; cancel beats order beats coin
  always_comb begin
    estado_nxt  = estado;
    credito_nxt = credito;
    tipo_nxt    = tipo_bebida;
    precio_nxt  = precio_q;
    vuelto_nxt  = 1'b0;
    rechazo_nxt = moneda_ok;   // coins are refused everywhere except a plain add in ESPERA
    cnt_nxt     = cnt;
    case (estado)
      ESPERA: begin
        if (cancelar && credito != 4'd0) begin
          estado_nxt = VUELTO;
        end else if (pedir_flanco) begin
          if (sel_ok && credito >= precio_sel) begin
            credito_nxt = credito - precio_sel;
            tipo_nxt    = seleccion;
            precio_nxt  = precio_sel;
            estado_nxt  = LANZAR;
          end else begin
            rechazo_nxt = 1'b1;
          end
        end else if (moneda_ok) begin
          if (suma > CMAX) rechazo_nxt = 1'b1;
          else begin
            rechazo_nxt = 1'b0;
            credito_nxt = suma[3:0];
          end
        end
      end
      LANZAR: begin
        estado_nxt = INICIO;
        cnt_nxt    = '0;
      end
      INICIO: begin
        if (ocupado) begin
          estado_nxt = FIN;
          cnt_nxt    = '0;
        end else if (cnt == CNT_FIN) begin
          // dispenser never answered: give the price back and refund it all
          credito_nxt = credito + precio_q;
          estado_nxt  = VUELTO;
          cnt_nxt     = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      FIN: begin
        if (!ocupado) estado_nxt = (credito != 4'd0) ? VUELTO : ESPERA;
      end
      VUELTO: begin
        // a low phase raises the pulse and takes one unit; leave after the last high phase
        if (vuelto_pulso) begin
          if (credito == 4'd0) estado_nxt = ESPERA;
        end else if (credito != 4'd0) begin
          vuelto_nxt  = 1'b1;
          credito_nxt = credito - 4'd1;
        end else begin
          estado_nxt = ESPERA;
        end
      end
      default: estado_nxt = ESPERA;
    endcase
  end

endmodule
